// File: rtl/sync_fifo_pro_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_pro_if
//   Handshake/status bundle between a producer/consumer pair and the
//   sync_fifo_pro FIFO. The producer/consumer side uses the master modport.
//   The FIFO uses the slave modport.
//
// Parameters
//   DATA_W : data word width
//   DEPTH  : FIFO depth; sets the width of o_count
//
// Signals (direction seen from the FIFO)
//   i_fwft       in   read mode request (0 standard, 1 first-word-fall-through)
//   i_clr        in   synchronous flush
//   i_wren       in   write request
//   i_wrdata     in   write data
//   i_rden       in   read/pop request
//   o_rddata     out  read data
//   o_rdvalid    out  o_rddata holds a popped/head word
//   o_full       out  occupancy == DEPTH
//   o_empty      out  occupancy == 0
//   o_alm_full   out  almost full
//   o_alm_empty  out  almost empty
//   o_count      out  occupancy
//   o_overflow   out  sticky, a write was dropped
//   o_underflow  out  sticky, a read of an empty FIFO occurred
//   o_parity_err out  parity error pulse (only with SYNC_FIFO_PARITY_EN)
//
// Optional feature macro: SYNC_FIFO_PARITY_EN
// -----------------------------------------------------------------------------
interface sync_fifo_pro_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              i_fwft;
  logic              i_clr;
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;
  logic              o_underflow;
`ifdef SYNC_FIFO_PARITY_EN
  logic              o_parity_err;
`endif

  modport master (
    output i_fwft, i_clr, i_wren, i_wrdata, i_rden,
`ifdef SYNC_FIFO_PARITY_EN
    input  o_parity_err,
`endif
    input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_fwft, i_clr, i_wren, i_wrdata, i_rden,
`ifdef SYNC_FIFO_PARITY_EN
    output o_parity_err,
`endif
    output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_pro.sv
// -----------------------------------------------------------------------------
// sync_fifo_pro
//   Parametrised single-clock FIFO. Any depth >= 2 is supported, including
//   depths that are not a power of two. Read mode is selectable at runtime
//   (standard or first-word-fall-through). The FIFO reports occupancy, has
//   registered full/empty/almost flags, a synchronous flush, and sticky
//   overflow/underflow flags.
//
// Parameters
//   DATA_W : word width (>= 1)
//   DEPTH  : number of entries (>= 2)
//   UPP_TH : o_alm_full when free entries <= UPP_TH
//   LOW_TH : o_alm_empty when occupancy <= LOW_TH
//
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-high reset. Release is expected to be
//         synchronous to clk.
//   bus : sync_fifo_pro_if.slave (handshake, data and status)
//
// Optional feature macro: SYNC_FIFO_PARITY_EN
//   When the macro is defined, each stored word carries an even-parity bit.
//   The parity is checked when the word is popped (standard mode) or when it
//   becomes the head (FWFT mode). A mismatch pulses bus.o_parity_err together
//   with o_rdvalid.
// -----------------------------------------------------------------------------
module sync_fifo_pro #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int UPP_TH = 4,
  parameter int LOW_TH = 2
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_pro_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] FULL_LVL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(DEPTH - UPP_TH);
  localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(LOW_TH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } rd_mode_e;

  // Pointers wrap explicitly, so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage and state
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  rd_mode_e          mode_q;
  logic              full_q, empty_q, alm_full_q, alm_empty_q;
  logic              overflow_q, underflow_q;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic              rdvalid_q, rdvalid_d;

  // Per-cycle decisions
  logic              wr_acc, rd_acc, wr_drop, rd_under, mode_load;
  logic [MEM_W-1:0]  wr_word;     // word as stored, including parity if enabled
  logic [MEM_W-1:0]  pop_word;    // entry popped this cycle (standard mode)
  logic [MEM_W-1:0]  next_head;   // entry at the head after this cycle (FWFT)
  logic              head_new;    // a different entry becomes the head next cycle

`ifdef SYNC_FIFO_PARITY_EN
  logic              parity_err_q, parity_err_d;
  assign wr_word = {^bus.i_wrdata, bus.i_wrdata};
`else
  assign wr_word = bus.i_wrdata;
`endif

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  // i_clr masks both requests, so a flush never raises an error flag.
  // A read of a full FIFO frees the slot, so the write in the same cycle is
  // also accepted.
  // The mode is latched only while the FIFO is empty and no write fills it.
  // A mode change therefore never affects words already queued.
  always_comb begin
    rd_acc    = !bus.i_clr && bus.i_rden && !empty_q;
    wr_acc    = !bus.i_clr && bus.i_wren && (!full_q || rd_acc);
    wr_drop   = !bus.i_clr && bus.i_wren && !wr_acc;
    rd_under  = !bus.i_clr && bus.i_rden && empty_q;
    mode_load = empty_q && !wr_acc;
  end

  // ---------------------------------------------------------------------------
  // Next pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every signal is assigned a default at the top of a combinational
  // block. Without the default, a path that skips the assignment infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // In FWFT mode the output register is loaded with the entry that will be the
  // head after this edge. If that entry is being written in this same cycle
  // (the FIFO was empty, or its only word is being popped), the memory does
  // not hold it yet. In that case the write data is forwarded instead.
  always_comb begin
    pop_word  = mem[rd_ptr_q];
    next_head = (wr_acc && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem[rd_ptr_d];
    head_new  = (count_d != '0) && (rd_acc || empty_q);

    rddata_d  = rddata_q;
    rdvalid_d = 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (!bus.i_clr) begin
      if (mode_q == MODE_FWFT) begin
        rdvalid_d = (count_d != '0);
        if (count_d != '0) rddata_d = next_head[DATA_W-1:0];
`ifdef SYNC_FIFO_PARITY_EN
        parity_err_d = head_new && (^next_head);
`endif
      end else begin
        rdvalid_d = rd_acc;
        if (rd_acc) rddata_d = pop_word[DATA_W-1:0];
`ifdef SYNC_FIFO_PARITY_EN
        parity_err_d = rd_acc && (^pop_word);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset. The pointers and the count decide
  // which entries are valid, and a reset on the array would prevent it from
  // mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_word;
  end

  // ---------------------------------------------------------------------------
  // Control state. All flags are computed from the next count, so they
  // describe the same cycle as o_count.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample their inputs at the same edge, whatever order they appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rddata_q    <= '0;
      rdvalid_q   <= 1'b0;
      mode_q      <= MODE_STD;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == FULL_LVL);
      empty_q     <= (count_d == '0);
      alm_full_q  <= (count_d >= AFULL_LVL);
      alm_empty_q <= (count_d <= AEMPTY_LVL);
      rddata_q    <= rddata_d;
      rdvalid_q   <= rdvalid_d;
      if (bus.i_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_drop)  overflow_q  <= 1'b1;
        if (rd_under) underflow_q <= 1'b1;
      end
      if (mode_load) mode_q <= rd_mode_e'(bus.i_fwft);
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign bus.o_parity_err = parity_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_rddata    = rddata_q;
  assign bus.o_rdvalid   = rdvalid_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_alm_full  = alm_full_q;
  assign bus.o_alm_empty = alm_empty_q;
  assign bus.o_count     = count_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_pro
//   Self-checking bench for sync_fifo_pro with DEPTH=6, UPP_TH=1, LOW_TH=1.
//   The reference model is a queue of words, updated once per clock from the
//   request signals. Inputs change 1 time unit after the rising edge.
//   Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sync_fifo_pro;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 6;
  localparam int UPP_TH = 1;
  localparam int LOW_TH = 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sync_fifo_pro_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_pro #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .UPP_TH(UPP_TH), .LOW_TH(LOW_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_q[$];
  bit                m_fwft, m_ovf, m_udf, m_rdvalid;
  logic [DATA_W-1:0] m_rddata;

  task automatic model_reset();
    m_q.delete();
    m_fwft = 0; m_ovf = 0; m_udf = 0; m_rdvalid = 0;
    m_rddata = '0;
  endtask

  task automatic model_step(input bit wren, input logic [DATA_W-1:0] wdata,
                            input bit rden, input bit clr, input bit fwft);
    int n = m_q.size();
    bit rd, wr, old_fwft;
    logic [DATA_W-1:0] popped = '0;
    if (clr) begin
      m_q.delete();
      m_ovf = 0; m_udf = 0; m_rdvalid = 0;
      if (n == 0) m_fwft = fwft;
    end else begin
      rd = rden && (n > 0);
      wr = wren && ((n < DEPTH) || rd);
      if (rden && n == 0) m_udf = 1;
      if (wren && !wr)    m_ovf = 1;
      old_fwft = m_fwft;
      if (n == 0 && !wr) m_fwft = fwft;
      if (rd) popped = m_q.pop_front();
      if (wr) m_q.push_back(wdata);
      if (old_fwft) begin
        m_rdvalid = (m_q.size() > 0);
        if (m_q.size() > 0) m_rddata = m_q[0];
      end else begin
        m_rdvalid = rd;
        if (rd) m_rddata = popped;
      end
    end
  endtask

  // One clock cycle. Requests are held across one rising edge, then dropped.
  task automatic cycle(input bit wren, input logic [DATA_W-1:0] wdata,
                       input bit rden, input bit clr);
    bus.i_wren = wren; bus.i_wrdata = wdata; bus.i_rden = rden; bus.i_clr = clr;
    @(posedge clk);
    model_step(wren, wdata, rden, clr, bus.i_fwft);
    #1;
    bus.i_wren = 1'b0; bus.i_rden = 1'b0; bus.i_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.i_fwft = 1'b0; bus.i_clr = 1'b0; bus.i_wren = 1'b0;
    bus.i_wrdata = '0; bus.i_rden = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_count !== '0)      begin errors++; $display("FAIL reset_count: got %0d want 0", bus.o_count); end
    checks++; if (bus.o_empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", bus.o_empty); end
    checks++; if (bus.o_alm_empty !== 1'b1) begin errors++; $display("FAIL reset_alm_empty: got %b want 1", bus.o_alm_empty); end
    checks++; if (bus.o_full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", bus.o_full); end
    checks++; if (bus.o_alm_full !== 1'b0) begin errors++; $display("FAIL reset_alm_full: got %b want 0", bus.o_alm_full); end
    checks++; if (bus.o_rddata !== '0)     begin errors++; $display("FAIL reset_rddata: got %h want 0", bus.o_rddata); end
    checks++; if (bus.o_rdvalid !== 1'b0)  begin errors++; $display("FAIL reset_rdvalid: got %b want 0", bus.o_rdvalid); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.o_overflow); end
    checks++; if (bus.o_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", bus.o_underflow); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_drain();
    cycle(0, '0, 0, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1, DATA_W'(k), 0, 0);
      checks++; if (bus.o_count !== CNT_W'(k)) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.o_count, k); end
      checks++; if (bus.o_alm_full !== (k >= 5)) begin errors++; $display("FAIL fill_alm_full: got %b want %b at count %0d", bus.o_alm_full, (k >= 5), k); end
      checks++; if (bus.o_full !== (k == DEPTH)) begin errors++; $display("FAIL fill_full: got %b want %b at count %0d", bus.o_full, (k == DEPTH), k); end
    end
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(0, '0, 1, 0);
      checks++; if (bus.o_rdvalid !== 1'b1 || bus.o_rddata !== DATA_W'(k)) begin
        errors++; $display("FAIL drain_data: got %h valid %b want %h", bus.o_rddata, bus.o_rdvalid, k);
      end
      checks++; if (bus.o_count !== CNT_W'(DEPTH - k)) begin errors++; $display("FAIL drain_count: got %0d want %0d", bus.o_count, DEPTH - k); end
      checks++; if (bus.o_alm_empty !== ((DEPTH - k) <= 1)) begin errors++; $display("FAIL drain_alm_empty: got %b at count %0d", bus.o_alm_empty, DEPTH - k); end
    end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.o_empty); end
    cycle(0, '0, 0, 0);
    checks++; if (bus.o_rdvalid !== 1'b0) begin errors++; $display("FAIL rdvalid_pulse: got %b want 0", bus.o_rdvalid); end
  endtask

  task automatic test_wrap();
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, DATA_W'(16'h10 + i), 0, 0);
      checks++; if (bus.o_count !== CNT_W'(1)) begin errors++; $display("FAIL wrap_count1: got %0d want 1", bus.o_count); end
      cycle(0, '0, 1, 0);
      checks++; if (bus.o_rdvalid !== 1'b1 || bus.o_rddata !== DATA_W'(16'h10 + i) || bus.o_count !== '0) begin
        errors++; $display("FAIL wrap_data: got %h valid %b count %0d want %h", bus.o_rddata, bus.o_rdvalid, bus.o_count, 16'h10 + i);
      end
    end
    checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
      errors++; $display("FAIL wrap_errors: got ovf %b udf %b want 0 0", bus.o_overflow, bus.o_underflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [DATA_W-1:0] exp_seq [DEPTH];
    cycle(0, '0, 0, 1);
    for (int k = 0; k < DEPTH; k++) cycle(1, DATA_W'(16'h40 + k), 0, 0);
    cycle(1, 16'h50, 1, 0);
    checks++; if (bus.o_count !== CNT_W'(DEPTH) || bus.o_overflow !== 1'b0) begin
      errors++; $display("FAIL full_rw: got count %0d ovf %b want %0d 0", bus.o_count, bus.o_overflow, DEPTH);
    end
    checks++; if (bus.o_rdvalid !== 1'b1 || bus.o_rddata !== 16'h40) begin
      errors++; $display("FAIL full_rw_data: got %h want 0040", bus.o_rddata);
    end
    for (int k = 0; k < DEPTH - 1; k++) exp_seq[k] = DATA_W'(16'h41 + k);
    exp_seq[DEPTH-1] = 16'h50;
    for (int k = 0; k < DEPTH; k++) begin
      cycle(0, '0, 1, 0);
      checks++; if (bus.o_rddata !== exp_seq[k]) begin errors++; $display("FAIL full_rw_drain: got %h want %h", bus.o_rddata, exp_seq[k]); end
    end
    cycle(0, '0, 0, 1);
    cycle(1, 16'h60, 1, 0);
    checks++; if (bus.o_count !== CNT_W'(1) || bus.o_underflow !== 1'b1 || bus.o_rdvalid !== 1'b0) begin
      errors++; $display("FAIL empty_rw: got count %0d udf %b valid %b want 1 1 0", bus.o_count, bus.o_underflow, bus.o_rdvalid);
    end
  endtask

  task automatic test_errors();
    cycle(0, '0, 0, 1);
    for (int k = 0; k < DEPTH; k++) cycle(1, DATA_W'(16'hA0 + k), 0, 0);
    cycle(1, 16'hAA, 0, 0);
    checks++; if (bus.o_overflow !== 1'b1 || bus.o_count !== CNT_W'(DEPTH)) begin
      errors++; $display("FAIL overflow: got ovf %b count %0d want 1 %0d", bus.o_overflow, bus.o_count, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      cycle(0, '0, 1, 0);
      checks++; if (bus.o_rddata !== DATA_W'(16'hA0 + k)) begin errors++; $display("FAIL overflow_data: got %h want %h", bus.o_rddata, 16'hA0 + k); end
    end
    cycle(0, '0, 1, 0);
    checks++; if (bus.o_underflow !== 1'b1 || bus.o_overflow !== 1'b1) begin
      errors++; $display("FAIL underflow: got udf %b ovf %b want 1 1", bus.o_underflow, bus.o_overflow);
    end
    cycle(0, '0, 0, 0);
    checks++; if (bus.o_underflow !== 1'b1 || bus.o_overflow !== 1'b1) begin
      errors++; $display("FAIL sticky: got udf %b ovf %b want 1 1", bus.o_underflow, bus.o_overflow);
    end
    cycle(0, '0, 0, 1);
    checks++; if (bus.o_count !== '0 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0 ||
                  bus.o_empty !== 1'b1 || bus.o_alm_empty !== 1'b1 || bus.o_full !== 1'b0) begin
      errors++; $display("FAIL clr: got count %0d ovf %b udf %b empty %b", bus.o_count, bus.o_overflow, bus.o_underflow, bus.o_empty);
    end
  endtask

  task automatic test_fwft();
    cycle(0, '0, 0, 1);
    bus.i_fwft = 1'b1;
    cycle(0, '0, 0, 0);
    cycle(1, 16'hBEEF, 0, 0);
    checks++; if (bus.o_rddata !== 16'hBEEF || bus.o_rdvalid !== 1'b1 || bus.o_empty !== 1'b0) begin
      errors++; $display("FAIL fwft_head: got %h valid %b empty %b want beef 1 0", bus.o_rddata, bus.o_rdvalid, bus.o_empty);
    end
    cycle(1, 16'h1234, 0, 0);
    checks++; if (bus.o_rddata !== 16'hBEEF || bus.o_rdvalid !== 1'b1) begin
      errors++; $display("FAIL fwft_hold: got %h valid %b want beef 1", bus.o_rddata, bus.o_rdvalid);
    end
    cycle(0, '0, 1, 0);
    checks++; if (bus.o_rddata !== 16'h1234 || bus.o_rdvalid !== 1'b1) begin
      errors++; $display("FAIL fwft_next: got %h valid %b want 1234 1", bus.o_rddata, bus.o_rdvalid);
    end
    cycle(0, '0, 1, 0);
    checks++; if (bus.o_empty !== 1'b1 || bus.o_rdvalid !== 1'b0) begin
      errors++; $display("FAIL fwft_pop: got empty %b valid %b want 1 0", bus.o_empty, bus.o_rdvalid);
    end
    bus.i_fwft = 1'b0;
    cycle(0, '0, 0, 0);
  endtask

  task automatic test_random();
    logic [CNT_W+6:0] exp_v, act_v;
    int wr_pct, rd_pct;
    for (int i = 0; i < 600; i++) begin
      if (i < 200)      begin wr_pct = 75; rd_pct = 30; end
      else if (i < 400) begin wr_pct = 30; rd_pct = 75; end
      else              begin wr_pct = 55; rd_pct = 55; end
      if ($urandom_range(19, 0) == 0) bus.i_fwft = ~bus.i_fwft;
      cycle($urandom_range(99, 0) < wr_pct, DATA_W'($urandom),
            $urandom_range(99, 0) < rd_pct, $urandom_range(59, 0) == 0);
      exp_v = {CNT_W'(m_q.size()), (m_q.size() == DEPTH), (m_q.size() == 0),
               (m_q.size() >= DEPTH - UPP_TH), (m_q.size() <= LOW_TH),
               m_ovf, m_udf, m_rdvalid};
      act_v = {bus.o_count, bus.o_full, bus.o_empty, bus.o_alm_full, bus.o_alm_empty,
               bus.o_overflow, bus.o_underflow, bus.o_rdvalid};
      checks++; if (act_v !== exp_v) begin
        errors++; $display("FAIL rand_status cyc %0d: got %b want %b (count,full,empty,af,ae,ovf,udf,valid)", i, act_v, exp_v);
      end
      if (m_rdvalid) begin
        checks++; if (bus.o_rddata !== m_rddata) begin
          errors++; $display("FAIL rand_data cyc %0d: got %h want %h", i, bus.o_rddata, m_rddata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_fwft = 1'b0;
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, DATA_W'(16'h20 + k), 0, 0);
    bus.i_wren = 1'b1; bus.i_wrdata = 16'h77;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
                  bus.o_rdvalid !== 1'b0 || bus.o_rddata !== '0 || bus.o_alm_empty !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got count %0d empty %b valid %b data %h", bus.o_count, bus.o_empty, bus.o_rdvalid, bus.o_rddata);
    end
    bus.i_wren = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(1, 16'h31, 0, 0);
    cycle(1, 16'h32, 0, 0);
    cycle(0, '0, 1, 0);
    checks++; if (bus.o_rdvalid !== 1'b1 || bus.o_rddata !== 16'h31 || bus.o_count !== CNT_W'(1)) begin
      errors++; $display("FAIL post_reset_read: got %h valid %b count %0d want 0031 1 1", bus.o_rddata, bus.o_rdvalid, bus.o_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors();
    test_fwft();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
